lfsr_req_arbiter: RTL and testbench



---
 rtl/lfsr_req_arbiter_if.sv | 30 +++
 rtl/lfsr_req_arbiter.sv | 179 +++++++++++++++++
 tb/tb_lfsr_req_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_req_arbiter_if.sv
// Request and generator signals of the LFSR request arbiter.
// The master side is the requesters plus the generator. The slave side is the arbiter.
interface lfsr_req_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] req_sw;
  logic [NREQ*DWIDTH-1:0] req_seq;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DWIDTH-1:0]      rsp_num;
  logic                   rsp_err;
  logic                   idle;
  logic                   gen_start;
  logic [DWIDTH-1:0]      gen_sw;
  logic [DWIDTH-1:0]      gen_seq;
  logic                   gen_busy;
  logic [DWIDTH-1:0]      gen_num;

  modport master (
    output req, req_sw, req_seq, gen_busy, gen_num,
    input  gnt, done, rsp_num, rsp_err, idle, gen_start, gen_sw, gen_seq
  );

  modport slave (
    input  req, req_sw, req_seq, gen_busy, gen_num,
    output gnt, done, rsp_num, rsp_err, idle, gen_start, gen_sw, gen_seq
  );
endinterface

// File: rtl/lfsr_req_arbiter.sv
// Round-robin scheduler that shares one LFSR sequence generator between NREQ requesters.
// A watchdog aborts a service whose generator never raises or never releases busy.
module lfsr_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  lfsr_req_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_HIT   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_HI,
    S_WAIT_LO,
    S_CAPTURE,
    S_ABORT
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [DWIDTH-1:0] r_rsp_num;
  logic              r_rsp_err;
  logic              r_idle;
  logic              r_gen_start;
  logic [DWIDTH-1:0] r_gen_sw;
  logic [DWIDTH-1:0] r_gen_seq;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     r_winner;
  logic [CW-1:0]     r_cnt;

  logic              w_found;
  logic              w_hi_found;
  logic [IW-1:0]     w_pick;
  logic [IW-1:0]     w_hi_pick;
  logic [NREQ-1:0]   w_onehot;
  logic [DWIDTH-1:0] w_sw;
  logic [DWIDTH-1:0] w_seq;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_cnt_hit;

  // Round-robin search: the lowest requester above r_last wins. If there is none,
  // the search wraps and the lowest asserted requester wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned and infers a latch.
    w_found    = 1'b0;
    w_pick     = '0;
    w_hi_found = 1'b0;
    w_hi_pick  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_found = 1'b1;
        w_pick  = IW'(i);
        if (IW'(i) > r_last) begin
          w_hi_found = 1'b1;
          w_hi_pick  = IW'(i);
        end
      end
    end
    if (w_hi_found) begin
      w_pick = w_hi_pick;
    end
  end

  always_comb begin
    w_onehot = '0;
    w_sw     = '0;
    w_seq    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IW'(i)) begin
        w_onehot[i] = 1'b1;
        w_sw        = bus.req_sw[i*DWIDTH +: DWIDTH];
        w_seq       = bus.req_seq[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // The counter reaches TIMEOUT on the same edge that enters ABORT.
  assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_hit = (r_cnt >= CNT_HIT);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rsp_num   <= '0;
      r_rsp_err   <= 1'b0;
      r_idle      <= 1'b1;
      r_gen_start <= 1'b0;
      r_gen_sw    <= '0;
      r_gen_seq   <= '0;
      r_last      <= LAST_INIT;
      r_winner    <= '0;
      r_cnt       <= '0;
    end else begin
      // NOTE: pulse outputs default low each clock, so a single state assignment makes a one-cycle pulse.
      r_gen_start <= 1'b0;
      r_done      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_LAUNCH;
            r_gnt       <= w_onehot;
            r_winner    <= w_pick;
            r_gen_sw    <= w_sw;
            r_gen_seq   <= w_seq;
            r_gen_start <= 1'b1;
            r_idle      <= 1'b0;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_hit) begin
            r_state <= S_ABORT;
          end else if (bus.gen_busy) begin
            r_state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          r_cnt <= w_cnt_nxt;
          // When busy falls on the same edge the watchdog expires, the completion wins.
          if (!bus.gen_busy) begin
            r_state <= S_CAPTURE;
          end else if (w_cnt_hit) begin
            r_state <= S_ABORT;
          end
        end
        S_CAPTURE: begin
          r_rsp_num <= bus.gen_num;
          r_rsp_err <= 1'b0;
          r_done    <= r_gnt;
          r_gnt     <= '0;
          r_last    <= r_winner;
          r_idle    <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_ABORT: begin
          r_rsp_num <= '0;
          r_rsp_err <= 1'b1;
          r_done    <= r_gnt;
          r_gnt     <= '0;
          r_last    <= r_winner;
          r_idle    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.rsp_num   = r_rsp_num;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.idle      = r_idle;
  assign bus.gen_start = r_gen_start;
  assign bus.gen_sw    = r_gen_sw;
  assign bus.gen_seq   = r_gen_seq;

endmodule

// File: tb/tb_lfsr_req_arbiter.sv
// Directed-vector bench for lfsr_req_arbiter: a cycle-counted generator model with hand-computed
// grant order, latencies and results. Outputs are sampled on the falling edge.
module tb_lfsr_req_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lfsr_req_arbiter_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

  lfsr_req_arbiter #(
    .NREQ   (NREQ),
    .DWIDTH (DW),
    .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int k, input logic [7:0] sw, input logic [7:0] seq);
    bus.req_sw[k*DW +: DW]  = sw;
    bus.req_seq[k*DW +: DW] = seq;
  endtask

  task automatic load_default_slots();
    for (int k = 0; k < NREQ; k++) begin
      set_slot(k, 8'(16 + k), 8'(32 + k));
    end
  endtask

  // One service, seen from the cycle in which gen_start is high (cycle 0).
  // The model raises busy at cycle hi_dly (0 means never) and drops it lo_len cycles later with num.
  task automatic serve(input string tag, input logic [3:0] exp_gnt,
                       input logic [7:0] exp_sw, input logic [7:0] exp_seq, input int exp_wait,
                       input int hi_dly, input int lo_len, input logic [7:0] num,
                       input logic exp_err, input logic [7:0] exp_num, input int exp_lat,
                       input logic [3:0] req_after, input bit scramble);
    int  w    = 0;
    int  c    = 0;
    bit  seen = 1'b0;
    while (bus.gen_start !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (bus.gen_start !== 1'b1) begin
      check({tag, ".start_timeout"}, 32'(0), 32'(1));
      return;
    end
    if (exp_wait >= 0) check({tag, ".start_wait"}, 32'(w), 32'(exp_wait));
    check({tag, ".gnt"},    32'(bus.gnt),     32'(exp_gnt));
    check({tag, ".gen_sw"}, 32'(bus.gen_sw),  32'(exp_sw));
    check({tag, ".gen_seq"},32'(bus.gen_seq), 32'(exp_seq));
    check({tag, ".idle_busy"}, 32'(bus.idle), 32'(0));
    while (!seen && c < 60) begin
      @(negedge clk);
      c++;
      if (bus.done !== '0) begin
        seen = 1'b1;
      end else begin
        if (c == 1) begin
          check({tag, ".start_pulse"}, 32'(bus.gen_start), 32'(0));
          check({tag, ".gnt_hold"},    32'(bus.gnt),       32'(exp_gnt));
          bus.req = req_after;
          if (scramble) begin
            bus.req_sw  = ~bus.req_sw;
            bus.req_seq = ~bus.req_seq;
          end
        end
        if (hi_dly > 0 && c == hi_dly) bus.gen_busy = 1'b1;
        if (hi_dly > 0 && c == hi_dly + lo_len) begin
          bus.gen_busy = 1'b0;
          bus.gen_num  = num;
        end
      end
    end
    check({tag, ".done_lat"},  32'(c),           32'(exp_lat));
    check({tag, ".done"},      32'(bus.done),    32'(exp_gnt));
    check({tag, ".rsp_num"},   32'(bus.rsp_num), 32'(exp_num));
    check({tag, ".rsp_err"},   32'(bus.rsp_err), 32'(exp_err));
    check({tag, ".gnt_clear"}, 32'(bus.gnt),     32'(0));
    check({tag, ".sw_held"},   32'(bus.gen_sw),  32'(exp_sw));
    check({tag, ".seq_held"},  32'(bus.gen_seq), 32'(exp_seq));
    check({tag, ".idle_back"}, 32'(bus.idle),    32'(1));
    bus.gen_busy = 1'b0;
    @(negedge clk);
    check({tag, ".done_one"},  32'(bus.done),    32'(0));
    check({tag, ".num_hold"},  32'(bus.rsp_num), 32'(exp_num));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst          = 1'b1;
    bus.req      = 4'b1111;
    bus.req_sw   = '0;
    bus.req_seq  = '0;
    bus.gen_busy = 1'b0;
    bus.gen_num  = '0;
    load_default_slots();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.gnt",       32'(bus.gnt),       32'(0));
    check("rst.done",      32'(bus.done),      32'(0));
    check("rst.idle",      32'(bus.idle),      32'(1));
    check("rst.gen_start", 32'(bus.gen_start), 32'(0));
    check("rst.gen_sw",    32'(bus.gen_sw),    32'(0));
    check("rst.gen_seq",   32'(bus.gen_seq),   32'(0));
    check("rst.rsp_num",   32'(bus.rsp_num),   32'(0));
    check("rst.rsp_err",   32'(bus.rsp_err),   32'(0));
    rst = 1'b0;

    // All four requesting from reset: 0,1,2,3,0 with one idle cycle between services
    serve("rr0", 4'b0001, 8'h10, 8'h20, 1, 1, 1, 8'h40, 1'b0, 8'h40, 4, 4'b1111, 1'b0);
    serve("rr1", 4'b0010, 8'h11, 8'h21, 0, 1, 1, 8'h41, 1'b0, 8'h41, 4, 4'b1111, 1'b0);
    serve("rr2", 4'b0100, 8'h12, 8'h22, 0, 1, 1, 8'h42, 1'b0, 8'h42, 4, 4'b1111, 1'b0);
    serve("rr3", 4'b1000, 8'h13, 8'h23, 0, 1, 1, 8'h43, 1'b0, 8'h43, 4, 4'b1111, 1'b0);
    serve("rr4", 4'b0001, 8'h10, 8'h20, 0, 1, 1, 8'h44, 1'b0, 8'h44, 4, 4'b0000, 1'b0);

    // Single request, req dropped and switches scrambled mid-service
    set_slot(0, 8'h03, 8'h05);
    bus.req = 4'b0001;
    serve("single", 4'b0001, 8'h03, 8'h05, 1, 2, 7, 8'h2A, 1'b0, 8'h2A, 11, 4'b0000, 1'b1);
    load_default_slots();

    // Rotation: after requester 2, req=0101 grants 0 before 2
    bus.req = 4'b0100;
    serve("rot_a", 4'b0100, 8'h12, 8'h22, 1, 1, 1, 8'h51, 1'b0, 8'h51, 4, 4'b0101, 1'b0);
    serve("rot_b", 4'b0001, 8'h10, 8'h20, 0, 1, 1, 8'h52, 1'b0, 8'h52, 4, 4'b0100, 1'b0);
    serve("rot_c", 4'b0100, 8'h12, 8'h22, 0, 1, 1, 8'h53, 1'b0, 8'h53, 4, 4'b0000, 1'b0);

    // Busy never rises: abort, then a normal service
    bus.gen_num = 8'h5A;
    bus.req     = 4'b0001;
    serve("tmo_lo", 4'b0001, 8'h10, 8'h20, 1, 0, 0, 8'h00, 1'b1, 8'h00, 17, 4'b0000, 1'b0);
    bus.req = 4'b0010;
    serve("after_tmo", 4'b0010, 8'h11, 8'h21, 1, 1, 2, 8'h33, 1'b0, 8'h33, 5, 4'b0000, 1'b0);

    // Busy never falls: abort from WAIT_LO
    bus.req = 4'b0100;
    serve("tmo_hi", 4'b0100, 8'h12, 8'h22, 1, 1, 100, 8'h99, 1'b1, 8'h00, 17, 4'b0000, 1'b0);

    // Busy falls on the edge the watchdog expires: completion wins
    bus.req = 4'b1000;
    serve("tie", 4'b1000, 8'h13, 8'h23, 1, 1, 14, 8'h77, 1'b0, 8'h77, 17, 4'b0000, 1'b0);

    // Busy high while idle is ignored
    bus.gen_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy.idle",  32'(bus.idle),      32'(1));
    check("idle_busy.gnt",   32'(bus.gnt),       32'(0));
    check("idle_busy.start", 32'(bus.gen_start), 32'(0));
    bus.gen_busy = 1'b0;

    // Reset during WAIT_LO
    bus.req = 4'b0010;
    begin
      int w = 0;
      while (bus.gen_start !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      check("mid_rst.start_seen", 32'(bus.gen_start), 32'(1));
    end
    check("mid_rst.gnt_pre", 32'(bus.gnt), 32'(4'b0010));
    @(negedge clk);
    bus.gen_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst.gnt",       32'(bus.gnt),       32'(0));
    check("mid_rst.gen_start", 32'(bus.gen_start), 32'(0));
    check("mid_rst.gen_sw",    32'(bus.gen_sw),    32'(0));
    check("mid_rst.gen_seq",   32'(bus.gen_seq),   32'(0));
    check("mid_rst.idle",      32'(bus.idle),      32'(1));
    bus.gen_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst.no_done", 32'(bus.done), 32'(0));
    end
    rst = 1'b0;
    serve("post_rst", 4'b0010, 8'h11, 8'h21, 1, 1, 1, 8'h66, 1'b0, 8'h66, 4, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
